// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// The producer/consumer side uses master; the adder uses slave.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Wide adder built from one 4-bit carry-lookahead slice, processing one
// nibble per clock LSB-first with the inter-nibble carry held in a register.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  nibble_serial_adder_if.slave bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, b_q, sum_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q, cout_q, ovf_q;
  logic [IDX_W+1:0] bit_base;
  logic [5:0]       slice;
  logic             last_nibble;

  // Returns {carry out of bit 3, carry into bit 3, 4-bit sum}; every carry is
  // a flat sum-of-products of generate/propagate terms, no ripple.
  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] p, g, c, s;
    p    = x ^ y;
    g    = x & y;
    c[0] = g[0] | (p[0] & ci);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ {c[2:0], ci};
    return {c[3], c[2], s};
  endfunction

  assign bit_base    = {idx_q, 2'b00};
  assign slice       = cla4(a_q[bit_base +: 4], b_q[bit_base +: 4], carry_q);
  assign last_nibble = (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last_nibble)   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.in_valid) begin
        a_q     <= bus.a;
        b_q     <= bus.b;
        carry_q <= bus.cin;
        idx_q   <= '0;
      end else if (state_q == RUN) begin
        sum_q[bit_base +: 4] <= slice[3:0];
        carry_q              <= slice[5];
        idx_q                <= last_nibble ? '0 : idx_q + 1'b1;
        // Top slice: carry into the MSB is c2, carry out is c3.
        if (last_nibble) begin
          cout_q <= slice[5];
          ovf_q  <= slice[5] ^ slice[4];
        end
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed bench for nibble_serial_adder against a plain
// arithmetic reference model.
module tb_nibble_serial_adder;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  nibble_serial_adder_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic, signed overflow from operand/result signs.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       output logic [W-1:0] s, output logic co, output logic ov);
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    s    = full[W-1:0];
    co   = full[W];
    ov   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endtask

  // Called at posedge+1; presents operands and returns just after the accept edge.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    int waited;
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("in_ready_wait", 64'(waited < 50), 64'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = ci;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.cin      = 1'($urandom);
  endtask

  // Waits for out_valid, checks latency and result; consumes if out_ready is high.
  task automatic collect(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci);
    logic [W-1:0] es;
    logic         ec, eo;
    int           cyc;
    model(a, b, ci, es, ec, eo);
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(NIBBLES));
    check({tag, "_sum"}, 64'(bus.sum), 64'(es));
    check({tag, "_cout"}, 64'(bus.cout), 64'(ec));
    check({tag, "_ovf"}, 64'(bus.overflow), 64'(eo));
    if (bus.out_ready) begin
      @(posedge clk); #1;
      check({tag, "_drop"}, 64'({bus.out_valid, bus.in_ready}), 64'b01);
    end
  endtask

  task automatic txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic ci);
    accept(a, b, ci);
    collect(tag, a, b, ci);
  endtask

  initial begin
    logic [W-1:0] ra, rb, xa, xb;
    logic         rc, xc;
    logic [W-1:0] es;
    logic         ec, eo;
    n_vec = 0;
    n_err = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    check("reset_ctl", 64'({bus.in_ready, bus.out_valid}), 64'b10);
    check("reset_data", 64'({bus.sum, bus.cout, bus.overflow}), 64'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    txn("d1234", 16'h1234, 16'h4321, 1'b0);
    txn("dFFFF", 16'hFFFF, 16'h0001, 1'b0);
    txn("d7FFF", 16'h7FFF, 16'h0001, 1'b0);
    txn("d0FFF", 16'h0FFF, 16'h0000, 1'b1);
    txn("d8000", 16'h8000, 16'h8000, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      txn("rand", ra, rb, rc);
    end

    // Backpressure in DONE with a pending new operand set.
    ra = 16'hA5C3; rb = 16'h6E91; rc = 1'b1;
    xa = 16'h3C7F; xb = 16'hC081; xc = 1'b0;
    bus.out_ready = 1'b0;
    accept(ra, rb, rc);
    collect("bp_first", ra, rb, rc);
    model(ra, rb, rc, es, ec, eo);
    bus.in_valid = 1'b1;
    bus.a        = xa;
    bus.b        = xb;
    bus.cin      = xc;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_ctl", 64'({bus.out_valid, bus.in_ready}), 64'b10);
      check("bp_hold_data", 64'({bus.sum, bus.cout, bus.overflow}), 64'({es, ec, eo}));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", 64'({bus.out_valid, bus.in_ready}), 64'b01);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_accepted", 64'(bus.in_ready), 64'd0);
    collect("bp_pending", xa, xb, xc);

    // Asynchronous reset after two nibbles of a transaction.
    accept(16'hFEDC, 16'h89AB, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ctl", 64'({bus.in_ready, bus.out_valid}), 64'b10);
    check("async_rst_data", 64'({bus.sum, bus.cout, bus.overflow}), 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    txn("post_rst", 16'h00FF, 16'h0001, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
